// File: rtl/multi_candle_flicker.sv
// Multi-channel candle flicker: per-channel LFSR-driven random targets, slew-limited
// brightness tracking and glitch-free PWM from one shared counter.
module multi_candle_flicker #(
  parameter int CHANNELS   = 4,
  parameter int PWM_WIDTH  = 8,
  parameter int FLKR_DIV   = 122,
  parameter int LFSR_DIV   = 4,
  parameter int MIN_BRIGHT = 64,
  parameter int STEP_UP    = 2,
  parameter int STEP_DN    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [PWM_WIDTH-1:0]          steady_level,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic                          frame,
  output logic [CHANNELS*PWM_WIDTH-1:0] brightness_all
);

  localparam int FW = (FLKR_DIV > 1) ? $clog2(FLKR_DIV) : 1;
  localparam int TW = (LFSR_DIV > 1) ? $clog2(LFSR_DIV) : 1;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_STEADY  = 2'b01;
  localparam logic [1:0] MODE_FLICKER = 2'b10;
  localparam logic [1:0] MODE_FADE_IN = 2'b11;

  localparam logic [PWM_WIDTH-1:0] PWM_MAX   = '1;
  localparam logic [PWM_WIDTH:0]   MAX_EXT   = {1'b0, PWM_MAX};
  localparam logic [PWM_WIDTH-1:0] MIN_B     = PWM_WIDTH'(MIN_BRIGHT);
  localparam logic [PWM_WIDTH:0]   UP_EXT    = (PWM_WIDTH+1)'(STEP_UP);
  localparam logic [PWM_WIDTH:0]   DN_EXT    = (PWM_WIDTH+1)'(STEP_DN);
  localparam logic [FW-1:0]        FLKR_LAST = FW'(FLKR_DIV - 1);
  localparam logic [TW-1:0]        LFSR_LAST = TW'(LFSR_DIV - 1);
  localparam logic [15:0]          LFSR_MASK = 16'hB400;

  function automatic logic [15:0] seed(input int c);
    logic [31:0] prod;
    logic [15:0] s;
    prod = 32'h1F35 * 32'(c + 1);
    s    = 16'hACE1 ^ prod[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  logic [FW-1:0]        cnt;
  logic [TW-1:0]        tcnt;
  logic [PWM_WIDTH-1:0] pcnt;
  logic [PWM_WIDTH-1:0] pcnt_next;
  logic                 flkr_tick;
  logic                 lfsr_tick;
  logic                 frame_tick;

  assign flkr_tick  = enable && (cnt == FLKR_LAST);
  assign lfsr_tick  = flkr_tick && (tcnt == LFSR_LAST);
  assign frame_tick = enable && (pcnt == PWM_MAX);
  assign pcnt_next  = enable ? pcnt + PWM_WIDTH'(1) : pcnt;
  assign frame      = frame_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tcnt <= '0;
      pcnt <= '0;
    end else if (enable) begin
      cnt <= flkr_tick ? '0 : cnt + FW'(1);
      if (flkr_tick) tcnt <= lfsr_tick ? '0 : tcnt + TW'(1);
      pcnt <= pcnt_next;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [15:0] SEED = seed(c);

    logic [15:0]          lfsr_q;
    logic [15:0]          lfsr_next;
    logic [PWM_WIDTH-1:0] target_q;
    logic [PWM_WIDTH-1:0] target_new;
    logic [PWM_WIDTH-1:0] bright_q;
    logic [PWM_WIDTH-1:0] bright_next;
    logic [PWM_WIDTH-1:0] duty_q;
    logic [PWM_WIDTH-1:0] duty_next;
    logic                 pwm_q;
    logic [1:0]           ch_mode;
    logic [PWM_WIDTH:0]   b_ext;
    logic [PWM_WIDTH:0]   t_ext;
    logic [PWM_WIDTH:0]   up_sum;
    logic [PWM_WIDTH:0]   dn_val;

    assign ch_mode    = mode[2*c +: 2];
    assign lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    assign target_new = (lfsr_next[PWM_WIDTH-1:0] < MIN_B) ? MIN_B : lfsr_next[PWM_WIDTH-1:0];
    assign b_ext      = {1'b0, bright_q};
    assign t_ext      = {1'b0, target_q};
    assign up_sum     = b_ext + UP_EXT;
    // Extended-width compare keeps the downward step from wrapping below the target.
    assign dn_val     = (b_ext > t_ext + DN_EXT) ? b_ext - DN_EXT : t_ext;
    assign duty_next  = frame_tick ? bright_q : duty_q;

    always_comb begin
      bright_next = bright_q;
      if (enable) begin
        unique case (ch_mode)
          MODE_OFF:     bright_next = '0;
          MODE_STEADY:  bright_next = steady_level;
          MODE_FLICKER: begin
            if (flkr_tick) begin
              if (b_ext < t_ext)      bright_next = (up_sum < t_ext) ? up_sum[PWM_WIDTH-1:0] : target_q;
              else if (b_ext > t_ext) bright_next = dn_val[PWM_WIDTH-1:0];
            end
          end
          MODE_FADE_IN: begin
            if (flkr_tick) bright_next = (up_sum < MAX_EXT) ? up_sum[PWM_WIDTH-1:0] : PWM_MAX;
          end
        endcase
      end
    end

    // Duty is only reloaded at the period boundary, so comparing against its
    // next value keeps the first cycle of each period consistent with the new duty.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lfsr_q   <= SEED;
        target_q <= MIN_B;
        bright_q <= '0;
        duty_q   <= '0;
        pwm_q    <= 1'b0;
      end else begin
        bright_q <= bright_next;
        if (lfsr_q == 16'h0000) begin
          lfsr_q <= SEED;
        end else if (lfsr_tick) begin
          lfsr_q   <= lfsr_next;
          target_q <= target_new;
        end
        if (frame_tick) duty_q <= bright_q;
        pwm_q <= enable && (pcnt_next < duty_next);
      end
    end

    assign pwm_out[c]                                = pwm_q;
    assign brightness_all[c*PWM_WIDTH +: PWM_WIDTH] = bright_q;
  end

endmodule

// File: doc/multi_candle_flicker.md
Name: multi_candle_flicker

Overview:
Multi-channel, parametrised successor to the single-LED candle flicker top. Each channel has its own LFSR, a slew-limited brightness tracker and a glitch-free PWM output. Per-channel modes are OFF, STEADY, FLICKER and FADE_IN. All prescalers are internal, and one shared PWM counter serves every channel.

Parameters:
CHANNELS, 4, number of independent LED channels (1..8)
PWM_WIDTH, 8, brightness/duty resolution in bits (4..12)
FLKR_DIV, 122, clk cycles per flicker tick (>=2)
LFSR_DIV, 4, flicker ticks per new random target (>=1)
MIN_BRIGHT, 64, floor applied to random targets
STEP_UP, 2, max brightness increase per flicker tick
STEP_DN, 1, max brightness decrease per flicker tick

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  global run; low freezes all state
mode  input  2*CHANNELS  per-channel mode, ch c at [2c+1:2c]; 00 OFF, 01 STEADY, 10 FLICKER, 11 FADE_IN
steady_level  input  PWM_WIDTH  brightness used by STEADY channels
pwm_out  output  CHANNELS  PWM drive, bit c = channel c
frame  output  1  one-cycle pulse at PWM period end
brightness_all  output  CHANNELS*PWM_WIDTH  current brightness registers, debug

Behaviour:
- Reset (reset=0, async): all counters 0; brightness[c]=0; duty[c]=0; target[c]=MIN_BRIGHT; lfsr[c]=SEED(c); pwm_out=0; frame=0.
- SEED(c) = 16'hACE1 ^ (16'h1F35*(c+1)), truncated to 16 bits. If the result is 0, use 16'h0001.
- Flicker prescaler: while enable=1, counts 0..FLKR_DIV-1 and wraps. flkr_tick = enable && cnt==FLKR_DIV-1, a one-cycle internal pulse.
- Target prescaler: counts flkr_ticks 0..LFSR_DIV-1. lfsr_tick = flkr_tick && tcnt==LFSR_DIV-1.
- LFSR: 16-bit Galois, right shift, mask 16'hB400, advances only on lfsr_tick. If the state is ever 0, reload SEED(c) on the next clk.
- Target update: on lfsr_tick, target[c] = max(lfsr_next[c][PWM_WIDTH-1:0], MIN_BRIGHT), using the post-shift LFSR value. All other modes still advance the LFSR and target.
- Brightness update: combinational next value, registered on every clk; slewed modes change only on flkr_tick.
  - OFF: brightness=0 at the next clk (no slew).
  - STEADY: brightness=steady_level at the next clk (no slew).
  - FLICKER: if b<target, b=min(b+STEP_UP, target); if b>target, b=max(b-STEP_DN, target); otherwise hold. Arithmetic uses PWM_WIDTH+1 bits, with no wrap or overshoot. On entry from another mode, slewing starts from the current b.
  - FADE_IN: b=min(b+STEP_UP, 2^PWM_WIDTH-1), then holds at max.
- PWM counter: one shared PWM_WIDTH-bit counter, increments each clk when enable=1, wraps 2^W-1 -> 0.
  - frame = enable && pcnt==2^W-1.
  - On frame, duty[c] <= brightness[c]. Duty changes only at period boundaries, so there are no mid-period glitches.
- PWM output: pwm_out[c] registered = enable && (pcnt_next < duty[c]), which gives 1-cycle latency from counter to output.
  - duty=0 gives a constant 0.
  - duty=2^W-1 gives high for 2^W-1 of 2^W cycles.
- enable=0: all counters, LFSRs, brightness and duty hold. pwm_out=0 and frame=0 from the next clk. Operation resumes from the held state.
- Simultaneous flkr_tick and lfsr_tick: the brightness step uses the OLD target; the new target applies from the next tick.
- Mode change mid-period: brightness changes immediately; pwm_out reflects it only after the next frame.
- Reset asserted mid-operation: everything returns to reset values asynchronously. After release, sequences repeat bit-exactly.

Test Plan:
Use bench params FLKR_DIV=4, LFSR_DIV=2, PWM_WIDTH=8, CHANNELS=4 unless stated.
- Reset/seed: hold reset=0, then release with mode=all FLICKER.
  - pwm_out=0 for the first 256 clks, since duty=0.
  - lfsr[0] after the first lfsr_tick (clk 8) = (16'hACE1^16'h1F35)>>1 ^ mask per LSB, checked against the reference model.
  - Each later target[c] is >= 64.
- STEADY duty: mode ch0=01, steady_level=8'd64.
  - After the first frame, each 256-cycle period shows exactly 64 high cycles on pwm_out[0], contiguous, starting 1 clk after pcnt=0.
- Slew limits: force target via ch0 FLICKER from b=0.
  - b rises by 2 per flkr_tick, never exceeds target, and never drops by more than 1 per tick.
  - Checked over 10,000 clks against the model.
- FADE_IN saturation: FADE_IN from b=250, STEP_UP=2.
  - b goes 252, 254, 255, then holds 255.
  - pwm_out high 255 of 256 cycles.
- OFF / enable freeze:
  - Switching ch1 to OFF gives brightness=0 on the next clk and pwm_out[1]=0 after the next frame.
  - enable=0 for 100 clks gives frame=0 and pwm_out=0, with counters unchanged.
  - After re-enable, the output trace equals the un-paused trace shifted by 100 clks.
- Reset mid-run: assert reset at clk 5,000 for 3 clks.
  - All outputs read 0 asynchronously.
  - After release, the first 2,000 clks of pwm_out match the first 2,000 clks of the original run exactly.
